// File: rtl/sync_fifo_flagged_if.sv
// Handshake and status bundle between a FIFO user (master) and sync_fifo_flagged (slave).
interface sync_fifo_flagged_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             rinc;
    logic             clr_err;
    logic [DSIZE-1:0] rdata;
    logic             rvalid;
    logic             wfull;
    logic             rempty;
    logic             walmost_full;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output winc, wdata, rinc, clr_err,
        input  rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, clr_err,
        output rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with registered count, almost-full/empty thresholds and sticky error flags.
// Latency: 1 cycle read (FWFT=0), head visible the cycle after the write edge (FWFT=1).
// Backpressure: writes dropped while wfull, reads dropped while rempty; each drop sets a sticky flag.
module sync_fifo_flagged #(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 4,
    parameter int AFULL_THR  = 12,
    parameter int AEMPTY_THR = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_flagged_if.slave fifo
);
    localparam int             DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C  = DEPTH[ASIZE:0];
    localparam logic [ASIZE:0] AFULL_C  = AFULL_THR[ASIZE:0];
    localparam logic [ASIZE:0] AEMPTY_C = AEMPTY_THR[ASIZE:0];

    logic [DSIZE-1:0] mem [DEPTH];

    logic [ASIZE:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic           wfull_q, wfull_d, rempty_q, rempty_d;
    logic           afull_q, afull_d, aempty_q, aempty_d;
    logic           ovf_q, ovf_d, udf_q, udf_d;
    logic           wr_ok, rd_ok;
    logic [ASIZE-1:0] waddr, raddr;

    assign waddr = wptr_q[ASIZE-1:0];
    assign raddr = rptr_q[ASIZE-1:0];

    // Every flag is computed from count_d so it lands on the same edge as count.
    always_comb begin
        wr_ok    = fifo.winc & ~wfull_q;
        rd_ok    = fifo.rinc & ~rempty_q;
        wptr_d   = wptr_q + {{ASIZE{1'b0}}, wr_ok};
        rptr_d   = rptr_q + {{ASIZE{1'b0}}, rd_ok};
        count_d  = count_q + {{ASIZE{1'b0}}, wr_ok} - {{ASIZE{1'b0}}, rd_ok};
        wfull_d  = (count_d == DEPTH_C);
        rempty_d = (count_d == '0);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
        ovf_d    = (fifo.winc & wfull_q)  | (ovf_q & ~fifo.clr_err);
        udf_d    = (fifo.rinc & rempty_q) | (udf_q & ~fifo.clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem[waddr] <= fifo.wdata;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign fifo.rdata  = mem[raddr];
            assign fifo.rvalid = ~rempty_q;
        end else begin : g_std
            logic [DSIZE-1:0] rdata_q;
            logic             rvalid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_ok;
                    if (rd_ok) begin
                        rdata_q <= mem[raddr];
                    end
                end
            end

            assign fifo.rdata  = rdata_q;
            assign fifo.rvalid = rvalid_q;
        end
    endgenerate

    assign fifo.count         = count_q;
    assign fifo.wfull         = wfull_q;
    assign fifo.rempty        = rempty_q;
    assign fifo.walmost_full  = afull_q;
    assign fifo.ralmost_empty = aempty_q;
    assign fifo.overflow      = ovf_q;
    assign fifo.underflow     = udf_q;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed bench: standard-read instance (a) covers fill/drain/wrap/errors/reset, FWFT instance (b) covers fall-through.
module tb_sync_fifo_flagged;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sync_fifo_flagged_if #(.DSIZE(8), .ASIZE(4)) ifa ();
    sync_fifo_flagged_if #(.DSIZE(8), .ASIZE(4)) ifb ();

    sync_fifo_flagged #(.DSIZE(8), .ASIZE(4), .AFULL_THR(12), .AEMPTY_THR(2), .FWFT(1'b0)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .fifo (ifa)
    );

    sync_fifo_flagged #(.DSIZE(8), .ASIZE(4), .AFULL_THR(12), .AEMPTY_THR(2), .FWFT(1'b1)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .fifo (ifb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ifa.winc = 0; ifa.wdata = 0; ifa.rinc = 0; ifa.clr_err = 0;
        ifb.winc = 0; ifb.wdata = 0; ifb.rinc = 0; ifb.clr_err = 0;

        // Reset state
        tick(); tick();
        rst_n = 1;
        chk("rst_count", 32'(ifa.count), 0);
        chk("rst_rempty", 32'(ifa.rempty), 1);
        chk("rst_wfull", 32'(ifa.wfull), 0);
        chk("rst_afull", 32'(ifa.walmost_full), 0);
        chk("rst_aempty", 32'(ifa.ralmost_empty), 1);
        chk("rst_ovf", 32'(ifa.overflow), 0);
        chk("rst_udf", 32'(ifa.underflow), 0);
        chk("rst_rvalid", 32'(ifa.rvalid), 0);
        chk("rst_rdata", 32'(ifa.rdata), 0);

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            ifa.winc = 1; ifa.wdata = 8'(i);
            tick();
            chk("fill_count", 32'(ifa.count), 32'(i + 1));
            chk("fill_afull", 32'(ifa.walmost_full), 32'((i + 1) >= 12));
            chk("fill_wfull", 32'(ifa.wfull), 32'((i + 1) == 16));
            chk("fill_aempty", 32'(ifa.ralmost_empty), 32'((i + 1) <= 2));
        end
        ifa.wdata = 8'hEE;
        tick();
        ifa.winc = 0;
        chk("ovf_count", 32'(ifa.count), 16);
        chk("ovf_flag", 32'(ifa.overflow), 1);

        // Drain with an idle cycle after each read to see the single-cycle rvalid
        for (int i = 0; i < 16; i++) begin
            ifa.rinc = 1;
            tick();
            ifa.rinc = 0;
            chk("drain_rvalid", 32'(ifa.rvalid), 1);
            chk("drain_rdata", 32'(ifa.rdata), 32'(i));
            chk("drain_count", 32'(ifa.count), 32'(15 - i));
            chk("drain_aempty", 32'(ifa.ralmost_empty), 32'((15 - i) <= 2));
            chk("drain_rempty", 32'(ifa.rempty), 32'(i == 15));
            tick();
            chk("drain_rvalid_drop", 32'(ifa.rvalid), 0);
            chk("drain_rdata_hold", 32'(ifa.rdata), 32'(i));
        end
        ifa.rinc = 1;
        tick();
        ifa.rinc = 0;
        chk("udf_flag", 32'(ifa.underflow), 1);
        chk("udf_rvalid", 32'(ifa.rvalid), 0);
        chk("udf_count", 32'(ifa.count), 0);
        ifa.clr_err = 1;
        tick();
        ifa.clr_err = 0;
        chk("clr_ovf", 32'(ifa.overflow), 0);
        chk("clr_udf", 32'(ifa.underflow), 0);

        // Wrap/concurrency at count 5
        for (int i = 0; i < 5; i++) begin
            ifa.winc = 1; ifa.wdata = 8'(8'h20 + i);
            tick();
        end
        chk("wrap_pre_count", 32'(ifa.count), 5);
        ifa.rinc = 1;
        for (int k = 0; k < 40; k++) begin
            ifa.wdata = 8'(8'h30 + k);
            tick();
            chk("wrap_count", 32'(ifa.count), 5);
            chk("wrap_rvalid", 32'(ifa.rvalid), 1);
            chk("wrap_rdata", 32'(ifa.rdata), (k < 5) ? 32'(8'h20 + k) : 32'(8'h30 + k - 5));
        end
        ifa.winc = 0; ifa.rinc = 0;
        chk("wrap_ovf", 32'(ifa.overflow), 0);
        chk("wrap_udf", 32'(ifa.underflow), 0);

        // Full with simultaneous write and read; head is 0x53
        for (int i = 0; i < 11; i++) begin
            ifa.winc = 1; ifa.wdata = 8'(8'h60 + i);
            tick();
        end
        chk("full_wfull", 32'(ifa.wfull), 1);
        ifa.rinc = 1; ifa.wdata = 8'hEE;
        tick();
        ifa.winc = 0;
        chk("full_sim_count", 32'(ifa.count), 15);
        chk("full_sim_ovf", 32'(ifa.overflow), 1);
        chk("full_sim_wfull", 32'(ifa.wfull), 0);
        chk("full_sim_rdata", 32'(ifa.rdata), 32'h53);
        for (int i = 0; i < 15; i++) tick();
        ifa.rinc = 0;
        chk("full_drain_last", 32'(ifa.rdata), 32'h6A);
        chk("full_drain_rempty", 32'(ifa.rempty), 1);
        ifa.clr_err = 1;
        tick();
        ifa.clr_err = 0;

        // Empty with simultaneous write and read
        ifa.winc = 1; ifa.rinc = 1; ifa.wdata = 8'h77;
        tick();
        ifa.winc = 0; ifa.rinc = 0;
        chk("empty_sim_count", 32'(ifa.count), 1);
        chk("empty_sim_udf", 32'(ifa.underflow), 1);
        chk("empty_sim_rvalid", 32'(ifa.rvalid), 0);
        chk("empty_sim_rempty", 32'(ifa.rempty), 0);
        ifa.rinc = 1;
        tick();
        chk("empty_sim_rdata", 32'(ifa.rdata), 32'h77);
        chk("empty_sim_count0", 32'(ifa.count), 0);
        // Set and clear in the same cycle: set wins
        ifa.clr_err = 1;
        tick();
        chk("set_wins_udf", 32'(ifa.underflow), 1);
        ifa.rinc = 0;
        tick();
        ifa.clr_err = 0;
        chk("clr_udf2", 32'(ifa.underflow), 0);

        // Mid-operation reset with count 9 and overflow set
        ifa.winc = 1;
        for (int i = 0; i < 17; i++) begin
            ifa.wdata = 8'(i);
            tick();
        end
        ifa.winc = 0; ifa.rinc = 1;
        for (int i = 0; i < 7; i++) tick();
        ifa.rinc = 0;
        chk("prerst_count", 32'(ifa.count), 9);
        chk("prerst_ovf", 32'(ifa.overflow), 1);
        rst_n = 0; ifa.winc = 1; ifa.rinc = 1; ifa.wdata = 8'h99;
        tick();
        rst_n = 1; ifa.winc = 0; ifa.rinc = 0;
        chk("midrst_count", 32'(ifa.count), 0);
        chk("midrst_rempty", 32'(ifa.rempty), 1);
        chk("midrst_ovf", 32'(ifa.overflow), 0);
        chk("midrst_udf", 32'(ifa.underflow), 0);
        chk("midrst_rvalid", 32'(ifa.rvalid), 0);
        chk("midrst_rdata", 32'(ifa.rdata), 0);
        chk("midrst_aempty", 32'(ifa.ralmost_empty), 1);

        // FWFT instance
        chk("fwft_idle_rvalid", 32'(ifb.rvalid), 0);
        ifb.winc = 1; ifb.wdata = 8'hA5;
        tick();
        ifb.winc = 0;
        chk("fwft_rdata", 32'(ifb.rdata), 32'hA5);
        chk("fwft_rvalid", 32'(ifb.rvalid), 1);
        ifb.rinc = 1;
        tick();
        ifb.rinc = 0;
        chk("fwft_pop_rvalid", 32'(ifb.rvalid), 0);
        chk("fwft_pop_rempty", 32'(ifb.rempty), 1);
        ifb.winc = 1; ifb.wdata = 8'h11;
        tick();
        ifb.wdata = 8'h22;
        tick();
        ifb.winc = 0;
        chk("fwft_head1", 32'(ifb.rdata), 32'h11);
        ifb.rinc = 1;
        tick();
        ifb.rinc = 0;
        chk("fwft_head2", 32'(ifb.rdata), 32'h22);
        chk("fwft_head2_rvalid", 32'(ifb.rvalid), 1);
        chk("fwft_count", 32'(ifb.count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
